// File: rtl/sw_test_status_mon.sv
// sw_test_status_mon: per-core status-word FSMs with aggregated done/pass verdict, fail mask and watchdog
module sw_test_status_mon #(
  parameter int                   NumChannels   = 2,
  parameter int                   AddrWidth     = 32,
  parameter logic [AddrWidth-1:0] StatusAddr    = '0,
  parameter int                   TimeoutCycles = 0,
  parameter bit                   FailFast      = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumChannels-1:0]           wr_valid_i,
  input  logic [NumChannels*AddrWidth-1:0] wr_addr_i,
  input  logic [NumChannels*16-1:0]        wr_data_i,
  input  logic [NumChannels-1:0]           chan_en_i,
  output logic                             done_o,
  output logic                             passed_o,
  output logic                             timeout_o,
  output logic [NumChannels-1:0]           fail_mask_o,
  output logic [NumChannels*3-1:0]         chan_state_o
);
  localparam logic [15:0] InBootRom = 16'hB090;
  localparam logic [15:0] InTest    = 16'h4354;
  localparam logic [15:0] InWfi     = 16'h1D1E;
  localparam logic [15:0] Passed    = 16'h900D;
  localparam logic [15:0] Failed    = 16'hBAAD;
  localparam int          CW        = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CW-1:0] TMax    = CW'(TimeoutCycles);
  localparam logic [CW-1:0] TLast   = CW'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);
  typedef enum logic [2:0] {IDLE, BOOT, TEST, WFI, PASS, FAIL} chan_state_t;
  chan_state_t st_q [NumChannels];
  chan_state_t st_d [NumChannels];
  logic [NumChannels-1:0] fin, fl, fl_d;
  logic [CW-1:0] cnt;
  logic all_final, any_fail, agg_done, to_hit;
  always_comb begin
    for (int k = 0; k < NumChannels; k++) begin
      st_d[k] = st_q[k];
      if (wr_valid_i[k] && wr_addr_i[k*AddrWidth +: AddrWidth] == StatusAddr) begin
        if (st_q[k] == PASS)
          st_d[k] = wr_data_i[k*16 +: 16] == Failed ? FAIL : PASS;
        else if (st_q[k] != FAIL)
          st_d[k] = wr_data_i[k*16 +: 16] == InBootRom ? BOOT :
                    wr_data_i[k*16 +: 16] == InTest    ? TEST :
                    wr_data_i[k*16 +: 16] == InWfi     ? WFI  :
                    wr_data_i[k*16 +: 16] == Passed    ? PASS :
                    wr_data_i[k*16 +: 16] == Failed    ? FAIL : st_q[k];
      end
    end
  end
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NumChannels; k++)
      st_q[k] <= rst_i ? IDLE : st_d[k];
  end
  always_comb begin
    chan_state_o = '0;
    fin = '0;
    fl = '0;
    fl_d = '0;
    for (int k = 0; k < NumChannels; k++) begin
      chan_state_o[k*3 +: 3] = st_q[k];
      fin[k] = st_q[k] == PASS || st_q[k] == FAIL;
      fl[k] = st_q[k] == FAIL;
      fl_d[k] = st_d[k] == FAIL;
    end
  end
  // With no enabled channel, completion can only come from the watchdog
  assign all_final = |chan_en_i && &(fin | ~chan_en_i);
  assign any_fail  = |(fl & chan_en_i);
  assign agg_done  = FailFast ? (any_fail || all_final) : all_final;
  assign to_hit    = TimeoutCycles > 0 && cnt == TLast && !done_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_o <= 1'b0;
      passed_o <= 1'b0;
      timeout_o <= 1'b0;
      fail_mask_o <= '0;
      cnt <= '0;
    end else if (!done_o) begin
      cnt <= cnt == TMax ? cnt : cnt + 1'b1;
      fail_mask_o <= fl_d;
      done_o <= agg_done || to_hit;
      timeout_o <= to_hit;
      passed_o <= agg_done && !any_fail && !to_hit;
    end
  end
endmodule

// File: tb/tb_sw_test_status_mon.sv
// tb_sw_test_status_mon: directed checks of fail-fast, wait-all and watchdog monitor variants
module tb_sw_test_status_mon;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] wr_valid = '0;
  logic [63:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0] en = 2'b11;
  logic ff_done, ff_pass, ff_to, nf_done, nf_pass, nf_to, to_done, to_pass, to_to;
  logic [1:0] ff_mask, nf_mask, to_mask;
  logic [5:0] ff_st, nf_st, to_st;
  int errors = 0;
  int checks = 0;
  int n;
  always #5 clk = ~clk;
  sw_test_status_mon #(.FailFast(1'b1)) u_ff (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .chan_en_i(en), .done_o(ff_done), .passed_o(ff_pass), .timeout_o(ff_to),
    .fail_mask_o(ff_mask), .chan_state_o(ff_st));
  sw_test_status_mon #(.FailFast(1'b0)) u_nf (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .chan_en_i(en), .done_o(nf_done), .passed_o(nf_pass), .timeout_o(nf_to),
    .fail_mask_o(nf_mask), .chan_state_o(nf_st));
  sw_test_status_mon #(.TimeoutCycles(100)) u_to (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .chan_en_i(en), .done_o(to_done), .passed_o(to_pass), .timeout_o(to_to),
    .fail_mask_o(to_mask), .chan_state_o(to_st));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask
  task automatic wr(input int ch, input logic [31:0] addr, input logic [15:0] data);
    wr_valid[ch] = 1'b1;
    wr_addr[ch*32 +: 32] = addr;
    wr_data[ch*16 +: 16] = data;
    tick();
    wr_valid = '0;
  endtask
  task automatic reset();
    rst = 1'b1;
    wr_valid = '0;
    tick();
    rst = 1'b0;
    n = 0;
  endtask
  initial begin
    #1;
    reset();
    check("rst_done", ff_done, 0);
    check("rst_pass", ff_pass, 0);
    check("rst_to", to_to, 0);
    check("rst_mask", ff_mask, 0);
    check("rst_state", ff_st, 0);
    wr(0, 0, 16'h1234);
    check("ignored_code", ff_st, 6'o00);
    wr(0, 0, 16'hB090);
    check("boot", ff_st, 6'o01);
    wr(0, 0, 16'h1D1E);
    check("wfi", ff_st, 6'o03);
    wr(0, 0, 16'h4354);
    check("test", ff_st, 6'o02);
    wr(0, 0, 16'h900D);
    wr(1, 0, 16'h900D);
    check("pass_state", ff_st, 6'o44);
    check("pass_not_yet", ff_done, 0);
    tick();
    check("pass_done", ff_done, 1);
    check("pass_verdict", ff_pass, 1);
    check("pass_mask", ff_mask, 2'b00);
    reset();
    wr(0, 0, 16'h4354);
    wr(1, 0, 16'hBAAD);
    check("ff_not_yet", ff_done, 0);
    tick();
    check("ff_done", ff_done, 1);
    check("ff_verdict", ff_pass, 0);
    check("ff_mask", ff_mask, 2'b10);
    wr(0, 0, 16'h900D);
    tick();
    check("ff_freeze_done", ff_done, 1);
    check("ff_freeze_pass", ff_pass, 0);
    check("ff_freeze_mask", ff_mask, 2'b10);
    reset();
    wr(0, 0, 16'hBAAD);
    repeat (39) tick();
    check("nf_wait", nf_done, 0);
    wr(1, 0, 16'h900D);
    check("nf_wait2", nf_done, 0);
    tick();
    check("nf_done", nf_done, 1);
    check("nf_verdict", nf_pass, 0);
    check("nf_mask", nf_mask, 2'b01);
    en = 2'b01;
    reset();
    wr(0, 4, 16'h900D);
    tick();
    check("bad_addr_state", ff_st, 0);
    check("bad_addr_done", ff_done, 0);
    wr(0, 0, 16'h900D);
    tick();
    check("en_done", ff_done, 1);
    check("en_verdict", ff_pass, 1);
    wr(0, 0, 16'hBAAD);
    tick();
    check("override_state", ff_st, 6'o05);
    check("override_mask_frozen", ff_mask, 2'b00);
    check("override_pass_frozen", ff_pass, 1);
    en = 2'b11;
    reset();
    wr(0, 0, 16'h4354);
    while (n < 99) tick();
    check("to_early", to_done, 0);
    tick();
    check("to_done", to_done, 1);
    check("to_flag", to_to, 1);
    check("to_verdict", to_pass, 0);
    reset();
    while (n < 98) tick();
    wr_valid = 2'b11;
    wr_addr = '0;
    wr_data = {16'h900D, 16'h900D};
    tick();
    wr_valid = '0;
    check("to_race_state", to_st, 6'o44);
    check("to_race_early", to_done, 0);
    tick();
    check("to_race_done", to_done, 1);
    check("to_race_flag", to_to, 1);
    check("to_race_verdict", to_pass, 0);
    reset();
    wr(0, 0, 16'h900D);
    check("pre_rst_state", ff_st, 6'o04);
    rst = 1'b1;
    wr(0, 0, 16'h4354);
    rst = 1'b0;
    check("mid_rst_state", ff_st, 0);
    check("mid_rst_done", ff_done, 0);
    wr_valid = 2'b11;
    wr_data = {16'h4354, 16'h4354};
    tick();
    wr_valid = '0;
    check("dual_write", ff_st, 6'o22);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
